// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Circular instruction buffer that sits between fetch and decode. Fetch
//   writes one or two instructions per cycle and decode reads one or two.
//   There is no bypass path, so a pushed instruction reaches the outputs one
//   cycle after it is written.
//
// Parameters
//   DEPTH           entry count (power of two, >= 4)
//
// Optional feature (macro FETCH_BUF_PC_EN)
//   When this macro is defined, each entry also holds the PC of its
//   instruction. This adds the ports if_pc, pc0_o and pc1_o.
//
// Ports
//   clk             clock; all state updates on its rising edge
//   rst             synchronous active-high reset
//   flush           discards buffered and same-cycle incoming instructions
//   if_valid        fetch offers a group
//   if_ready        at least two free entries (current count only)
//   if_inst0/1      group instructions in program order
//   if_inst1_en     if_inst1 is part of the group
//   if_pc           PC of if_inst0; if_inst1 is at if_pc+4 (PC build only)
//   fifo_valid      at least one entry buffered
//   fifo_ready      decode consumes the head group
//   inst0_o/inst1_o entries at rptr and rptr+1
//   pc0_o/pc1_o     PCs of those entries (PC build only)
//   inst1_valid     inst1_o holds a real instruction
//   fetch_buf_empty buffer holds zero entries
// -----------------------------------------------------------------------------
module fetch_buffer #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_inst0,
   input  logic [31:0] if_inst1,
   input  logic        if_inst1_en,
`ifdef FETCH_BUF_PC_EN
   input  logic [31:0] if_pc,
   output logic [31:0] pc0_o,
   output logic [31:0] pc1_o,
`endif
   output logic        fifo_valid,
   input  logic        fifo_ready,
   output logic [31:0] inst0_o,
   output logic [31:0] inst1_o,
   output logic        inst1_valid,
   output logic        fetch_buf_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;   // count spans 0..DEPTH inclusive

   localparam logic [CW-1:0] C_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] C_TWO   = {{(CW-2){1'b0}}, 2'd2};
   localparam logic [CW-1:0] C_LIMIT = CW'(DEPTH - 2);
   localparam logic [AW-1:0] P_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] P_TWO   = {{(AW-2){1'b0}}, 2'd2};

   logic [31:0]   r_mem [DEPTH];
`ifdef FETCH_BUF_PC_EN
   logic [31:0]   r_pc  [DEPTH];
`endif
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   logic          w_push;
   logic          w_pop;
   logic          w_pop_two;
   logic [AW-1:0] w_wptr1;
   logic [AW-1:0] w_rptr1;
   logic [CW-1:0] w_push_n;
   logic [CW-1:0] w_pop_n;

   // ---------------------------------------------------------------------------
   // Status outputs. if_ready is based only on the current count; a pop in
   // the same cycle does not free space early.
   // ---------------------------------------------------------------------------
   assign if_ready        = (r_count <= C_LIMIT);
   assign fifo_valid      = (r_count != '0);
   assign inst1_valid     = (r_count >= C_TWO);
   assign fetch_buf_empty = (r_count == '0);

   // Flush blocks both handshakes, so a flush cycle has no side effects
   // other than clearing the buffer.
   assign w_push    = if_valid & if_ready & ~flush;
   assign w_pop     = fifo_valid & fifo_ready & ~flush;
   assign w_pop_two = inst1_valid;

   // The buffer size is a power of two, so pointer wrap is natural
   // overflow of the AW-bit adds.
   assign w_wptr1 = r_wptr + P_ONE;
   assign w_rptr1 = r_rptr + P_ONE;

   assign w_push_n = !w_push    ? '0 : (if_inst1_en ? C_TWO : C_ONE);
   assign w_pop_n  = !w_pop     ? '0 : (w_pop_two   ? C_TWO : C_ONE);

   // Reads are combinational from storage; a slot written this cycle is
   // only reachable through r_count next cycle, which gives a one-cycle
   // latency with no bypass.
   assign inst0_o = r_mem[r_rptr];
   assign inst1_o = r_mem[w_rptr1];
`ifdef FETCH_BUF_PC_EN
   assign pc0_o   = r_pc[r_rptr];
   assign pc1_o   = r_pc[w_rptr1];
`endif

   // ---------------------------------------------------------------------------
   // Pointers and count
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= if_inst1_en ? (r_wptr + P_TWO) : w_wptr1;
         if (w_pop)
            r_rptr <= w_pop_two ? (r_rptr + P_TWO) : w_rptr1;
         r_count <= r_count + w_push_n - w_pop_n;
      end
   end

   // ---------------------------------------------------------------------------
   // Entry storage. It is not reset: the contents do not matter while
   // count is zero. A write is gated by rst so that a reset cycle leaves
   // the storage untouched.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wptr] <= if_inst0;
         if (if_inst1_en)
            r_mem[w_wptr1] <= if_inst1;
      end
   end

`ifdef FETCH_BUF_PC_EN
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_pc[r_wptr] <= if_pc;
         if (if_inst1_en)
            r_pc[w_wptr1] <= if_pc + 32'd4;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer. The reference model is a queue of
// instructions in program order. A model process updates the queue on each
// rising edge from the driven inputs. A monitor on the falling edge compares
// every DUT output against the front of the queue.
module tb_fetch_buffer;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst, flush, if_valid, if_inst1_en, fifo_ready;
   logic [31:0] if_inst0, if_inst1, if_pc;
   logic        if_ready, fifo_valid, inst1_valid, fetch_buf_empty;
   logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_inst0(if_inst0), .if_inst1(if_inst1), .if_inst1_en(if_inst1_en),
`ifdef FETCH_BUF_PC_EN
      .if_pc(if_pc), .pc0_o(pc0_o), .pc1_o(pc1_o),
`endif
      .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
      .inst0_o(inst0_o), .inst1_o(inst1_o),
      .inst1_valid(inst1_valid), .fetch_buf_empty(fetch_buf_empty)
   );

`ifndef FETCH_BUF_PC_EN
   assign pc0_o = '0;
   assign pc1_o = '0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } ent_t;

   ent_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model. Its rules come directly from the buffer's behaviour:
   // - accept a group when at least two slots are free;
   // - hand out two entries per pop when two exist, otherwise one;
   // - reset and flush empty the buffer.
   always @(posedge clk) begin
      int   n;
      ent_t e;
      n = q.size();
      if (rst || flush) begin
         q.delete();
      end else begin
         if (fifo_ready && n >= 1) begin
            void'(q.pop_front());
            if (n >= 2) void'(q.pop_front());
         end
         if (if_valid && (DEPTH - n) >= 2) begin
            e.inst = if_inst0; e.pc = if_pc;
            q.push_back(e);
            if (if_inst1_en) begin
               e.inst = if_inst1; e.pc = if_pc + 32'd4;
               q.push_back(e);
            end
         end
      end
   end

   // Monitor: outputs are a function of buffered state only, so they are
   // sampled mid-cycle.
   always @(negedge clk) begin
      int n;
      n = q.size();
      chk("fifo_valid",      {31'd0, fifo_valid},      {31'd0, n >= 1});
      chk("inst1_valid",     {31'd0, inst1_valid},     {31'd0, n >= 2});
      chk("fetch_buf_empty", {31'd0, fetch_buf_empty}, {31'd0, n == 0});
      chk("if_ready",        {31'd0, if_ready},        {31'd0, (DEPTH - n) >= 2});
      if (n >= 1) chk("inst0_o", inst0_o, q[0].inst);
      if (n >= 2) chk("inst1_o", inst1_o, q[1].inst);
`ifdef FETCH_BUF_PC_EN
      if (n >= 1) chk("pc0_o", pc0_o, q[0].pc);
      if (n >= 2) chk("pc1_o", pc1_o, q[1].pc);
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; flush = 0; if_valid = 0; fifo_ready = 0;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b,
                       input logic en, input logic [31:0] pc);
      if_valid = 1; if_inst0 = a; if_inst1 = b; if_inst1_en = en; if_pc = pc;
      step();
      if_valid = 0;
   endtask

   task automatic pop();
      fifo_ready = 1;
      step();
      fifo_ready = 0;
   endtask

   initial begin
      rst = 1; flush = 0; if_valid = 0; fifo_ready = 0;
      if_inst0 = '0; if_inst1 = '0; if_inst1_en = 0; if_pc = '0;
      step(); step();
      idle(); step();

      // First 2-wide push becomes visible one cycle later.
      push(32'h11, 32'h22, 1, 32'h1C000000);
      step();
      pop(); step();

      // Fill to DEPTH while decode stalls; if_ready drops.
      // A pop frees space one cycle later.
      for (int i = 0; i < 4; i++)
         push(32'h100 + 2*i, 32'h101 + 2*i, 1, 32'h1000 + 8*i);
      step();
      pop(); step();
      rst = 1; step(); idle(); step();

      // Single instruction in, then out.
      push(32'h33, 32'h0, 0, 32'h2000);
      step();
      pop(); step();

      // Walk both pointers to 7 with singles, then push a group that
      // straddles the wrap point.
      rst = 1; step(); idle();
      for (int i = 0; i < 7; i++) push(32'h200 + i, 32'h0, 0, 32'h3000 + 4*i);
      for (int i = 0; i < 4; i++) pop();
      push(32'hA, 32'hB, 1, 32'h4000);
      step();
      pop(); step();

      // Build a count of 5, then push, pop and flush together.
      push(32'h51, 32'h52, 1, 32'h5000);
      push(32'h53, 32'h54, 1, 32'h5008);
      push(32'h55, 32'h0, 0, 32'h5010);
      if_valid = 1; if_inst0 = 32'h56; if_inst1 = 32'h57; if_inst1_en = 1;
      fifo_ready = 1; flush = 1;
      step();
      idle(); step();

      // PC tracking.
      push(32'h61, 32'h62, 1, 32'h1C000000);
      step();
      pop(); step();

      // Random traffic with occasional flush and reset.
      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 99) == 0);
         flush       = ($urandom_range(0, 39) == 0);
         if_valid    = ($urandom_range(0, 2) != 0);
         if_inst1_en = $urandom_range(0, 1);
         fifo_ready  = ($urandom_range(0, 2) == 0);
         if_inst0    = $urandom;
         if_inst1    = $urandom;
         if_pc       = {$urandom, 2'b00} ;
         step();
      end
      idle(); step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, >=4).
REQ-002 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have flush  input  1  discard all buffered and incoming instructions.
REQ-005 SHALL have if_valid  input  1  fetch stage offers an instruction group.
REQ-006 SHALL have if_ready  output  1  buffer can accept a group this cycle.
REQ-007 SHALL have if_inst0, if_inst1  input  32 each  instructions in program order.
REQ-008 SHALL have if_inst1_en  input  1  if_inst1 valid (0 = single-instruction group).
REQ-009 SHALL have fifo_valid  output  1  at least one instruction at head.
REQ-010 SHALL have fifo_ready  input  1  decode stage consumes head group.
REQ-011 SHALL have inst0_o, inst1_o  output  32 each  head and head+1 entries.
REQ-012 SHALL have inst1_valid  output  1  inst1_o holds a real instruction.
REQ-013 SHALL have fetch_buf_empty  output  1  buffer holds zero entries.

Function
REQ-014 SHALL be a circular buffer of DEPTH entries with wrapping write pointer, read pointer and count (0..DEPTH).
REQ-015 SHALL drive if_ready = 1 when DEPTH - count >= 2, computed from current count only (no same-cycle pop credit).
REQ-016 SHALL on push (if_valid & if_ready & !flush) write if_inst0, then if_inst1 if if_inst1_en; write pointer advances by 1 or 2 modulo DEPTH.
REQ-017 SHALL drive fifo_valid = (count >= 1), inst1_valid = (count >= 2), fetch_buf_empty = (count == 0).
REQ-018 SHALL drive inst0_o/inst1_o combinationally from entries rptr and rptr+1 (mod DEPTH); inst1_o is don't-care when inst1_valid = 0.
REQ-019 SHALL on pop (fifo_valid & fifo_ready & !flush) advance read pointer by 2 if count >= 2, else by 1.
REQ-020 SHALL allow push and pop in one cycle; count' = count + pushed - popped.
REQ-021 SHALL not bypass: pushed data becomes visible at the outputs one cycle after the push (minimum latency 1 cycle).
REQ-022 SHALL on flush zero count and both pointers next cycle, ignoring any same-cycle push or pop.
REQ-023 SHALL ignore fifo_ready while fifo_valid = 0 and if_valid while if_ready = 0, with no state change.
REQ-024 SHALL handle pointer wrap-around so a two-entry push or pop straddling entry DEPTH-1 to 0 stays in order.

Reset
REQ-025 SHALL on rst set count, write and read pointers to 0: fifo_valid = 0, inst1_valid = 0, fetch_buf_empty = 1, if_ready = 1.
REQ-026 SHALL give rst priority over flush, push and pop; rst mid-operation discards all contents.
REQ-027 SHALL not reset the entry storage; inst0_o/inst1_o are don't-care while fifo_valid = 0.

Configuration
REQ-028 SHALL, when FETCH_BUF_PC_EN is defined, add if_pc input 32 (address of if_inst0; if_inst1 at if_pc+4), pc0_o/pc1_o outputs 32 each, stored per entry and shifted with the instructions.
REQ-029 SHALL, when FETCH_BUF_PC_EN is undefined, omit the PC ports and storage; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, push {0x11,0x22} inst1_en=1 -> next cycle fifo_valid=1, inst1_valid=1, inst0_o=0x11, inst1_o=0x22, fetch_buf_empty=0.
REQ-031 SHALL cover: fill DEPTH=8 with four 2-wide pushes, fifo_ready=0 -> count 8, if_ready=0; one pop -> if_ready=1 the following cycle, not before.
REQ-032 SHALL cover: push single 0x33 (inst1_en=0) into empty buffer, then pop -> inst1_valid=0, one entry removed, fetch_buf_empty=1 afterward.
REQ-033 SHALL cover: wptr=rptr=7, push {0xA,0xB} -> entries 7 and 0 written; output shows 0xA,0xB in order; pop returns count to 0.
REQ-034 SHALL cover: count 5 with simultaneous push and pop and flush=1 -> next cycle count 0, fifo_valid=0, if_ready=1.
REQ-035 SHALL cover: with FETCH_BUF_PC_EN defined, push if_pc=0x1C000000 2-wide -> pc0_o=0x1C000000, pc1_o=0x1C000004.
